// File: rtl/ddr3_axi_req_split_pkg.sv
// Shared constants for the DDR3 AXI request front-end: burst encoding,
// splitter FSM states and arbitration modes.
package ddr3_axi_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;

  localparam int ARB_RR      = 0;
  localparam int ARB_RD_PRIO = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

endpackage

// File: rtl/ddr3_axi_req_split_if.sv
// AXI AW/AR request channels, memory-controller command ports and completion
// pulses of the request splitter; slave is the splitter's view.
interface ddr3_axi_req_split_if #(
  parameter int ADDRS         = 32,
  parameter int AXI_ID_WIDTH  = 4,
  parameter int MEM_ID_WIDTH  = 4,
  parameter int MEM_BURST_LEN = 4
);
  localparam int LENW = $clog2(MEM_BURST_LEN);

  logic                    axi_awvalid_i, axi_awready_o;
  logic [ADDRS-1:0]        axi_awaddr_i;
  logic [AXI_ID_WIDTH-1:0] axi_awid_i;
  logic [7:0]              axi_awlen_i;
  logic [1:0]              axi_awburst_i;

  logic                    axi_arvalid_i, axi_arready_o;
  logic [ADDRS-1:0]        axi_araddr_i;
  logic [AXI_ID_WIDTH-1:0] axi_arid_i;
  logic [7:0]              axi_arlen_i;
  logic [1:0]              axi_arburst_i;

  logic                    mem_wrreq_o, mem_wrack_i, mem_wrerr_i, mem_wrlst_o;
  logic [LENW-1:0]         mem_wrlen_o;
  logic [MEM_ID_WIDTH-1:0] mem_wrtid_o;
  logic [ADDRS-1:0]        mem_wradr_o;

  logic                    mem_rdreq_o, mem_rdack_i, mem_rderr_i, mem_rdlst_o;
  logic [LENW-1:0]         mem_rdlen_o;
  logic [MEM_ID_WIDTH-1:0] mem_rdtid_o;
  logic [ADDRS-1:0]        mem_rdadr_o;

  logic                    wr_done_o, wr_done_err_o;
  logic [AXI_ID_WIDTH-1:0] wr_done_id_o;
  logic                    rd_done_o, rd_done_err_o;
  logic [AXI_ID_WIDTH-1:0] rd_done_id_o;

  modport slave (
    input  axi_awvalid_i, axi_awaddr_i, axi_awid_i, axi_awlen_i, axi_awburst_i,
    input  axi_arvalid_i, axi_araddr_i, axi_arid_i, axi_arlen_i, axi_arburst_i,
    input  mem_wrack_i, mem_wrerr_i, mem_rdack_i, mem_rderr_i,
    output axi_awready_o, axi_arready_o,
    output mem_wrreq_o, mem_wrlst_o, mem_wrlen_o, mem_wrtid_o, mem_wradr_o,
    output mem_rdreq_o, mem_rdlst_o, mem_rdlen_o, mem_rdtid_o, mem_rdadr_o,
    output wr_done_o, wr_done_id_o, wr_done_err_o,
    output rd_done_o, rd_done_id_o, rd_done_err_o
  );

  modport master (
    output axi_awvalid_i, axi_awaddr_i, axi_awid_i, axi_awlen_i, axi_awburst_i,
    output axi_arvalid_i, axi_araddr_i, axi_arid_i, axi_arlen_i, axi_arburst_i,
    output mem_wrack_i, mem_wrerr_i, mem_rdack_i, mem_rderr_i,
    input  axi_awready_o, axi_arready_o,
    input  mem_wrreq_o, mem_wrlst_o, mem_wrlen_o, mem_wrtid_o, mem_wradr_o,
    input  mem_rdreq_o, mem_rdlst_o, mem_rdlen_o, mem_rdtid_o, mem_rdadr_o,
    input  wr_done_o, wr_done_id_o, wr_done_err_o,
    input  rd_done_o, rd_done_id_o, rd_done_err_o
  );

endinterface

// File: rtl/ddr3_axi_req_split_arbiter.sv
// AW/AR grant logic: round-robin, or read priority with a write starvation
// limit. Grants are combinational; pointer and counter update on each grant.
module ddr3_rw_arbiter
  import ddr3_axi_pkg::*;
#(
  parameter int ARB_MODE      = ARB_RR,
  parameter int WR_STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req_w,
  input  logic req_r,
  input  logic idle,
  output logic grant_w,
  output logic grant_r
);
  localparam int SW = $clog2(WR_STARVE_MAX + 2);

  logic          last_w;
  logic [SW-1:0] starve_cnt;
  logic          w_wins;

  always_comb begin
    w_wins = 1'b1;
    if (req_r) begin
      if (ARB_MODE == ARB_RD_PRIO) w_wins = (starve_cnt == SW'(WR_STARVE_MAX));
      else                         w_wins = !last_w;
    end
  end

  assign grant_w = idle & req_w & w_wins;
  assign grant_r = idle & req_r & !grant_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_w     <= 1'b0;
      starve_cnt <= '0;
    end else if (grant_w) begin
      last_w     <= 1'b1;
      starve_cnt <= '0;
    end else if (grant_r) begin
      last_w <= 1'b0;
      if (req_w && starve_cnt != SW'(WR_STARVE_MAX)) starve_cnt <= starve_cnt + SW'(1);
    end
  end

endmodule

// File: rtl/ddr3_axi_req_split.sv
// Splits arbitrated AXI AW/AR bursts into memory commands of at most
// MEM_BURST_LEN beats, tagged in acceptance order, and pulses completion.
module ddr3_axi_req_split
  import ddr3_axi_pkg::*;
#(
  parameter int ADDRS         = 32,
  parameter int WIDTH         = 32,
  parameter int AXI_ID_WIDTH  = 4,
  parameter int MEM_ID_WIDTH  = 4,
  parameter int MEM_BURST_LEN = 4,
  parameter int ARB_MODE      = ARB_RR,
  parameter int WR_STARVE_MAX = 4
) (
  input logic                 clock,
  input logic                 reset,
  ddr3_axi_req_split_if.slave bus
);
  localparam int               MASKS    = WIDTH / 8;
  localparam int               ASH      = $clog2(MASKS);
  localparam int               LENW     = $clog2(MEM_BURST_LEN);
  localparam logic [ADDRS-1:0] LOW_MASK = ADDRS'(MASKS - 1);
  localparam logic [8:0]       MBL9     = 9'(MEM_BURST_LEN);

  state_t                  state, state_nx;
  logic [8:0]              remaining, remaining_nx;
  logic [ADDRS-1:0]        adr, adr_nx;
  logic [AXI_ID_WIDTH-1:0] aid, aid_nx, done_id, done_id_nx;
  logic [MEM_ID_WIDTH-1:0] tag, tag_nx, tid, tid_nx;
  logic                    err, err_nx, done_err, done_err_nx;
  logic                    wr_done, wr_done_nx, rd_done, rd_done_nx;

  logic       grant_w, grant_r, idle, wr_act, rd_act, ack, ack_err, last;
  logic [8:0] chunk;

  assign idle    = (state == ST_IDLE);
  assign wr_act  = (state == ST_WRITE);
  assign rd_act  = (state == ST_READ);
  assign chunk   = (remaining > MBL9) ? MBL9 : remaining;
  assign last    = (remaining <= MBL9);
  // acks on the channel not currently commanding are ignored
  assign ack     = (wr_act & bus.mem_wrack_i) | (rd_act & bus.mem_rdack_i);
  assign ack_err = (wr_act & bus.mem_wrerr_i) | (rd_act & bus.mem_rderr_i);

  ddr3_rw_arbiter #(
    .ARB_MODE      (ARB_MODE),
    .WR_STARVE_MAX (WR_STARVE_MAX)
  ) u_arb (
    .clk     (clock),
    .rst     (reset),
    .req_w   (bus.axi_awvalid_i),
    .req_r   (bus.axi_arvalid_i),
    .idle    (idle),
    .grant_w (grant_w),
    .grant_r (grant_r)
  );

  always_comb begin
    state_nx     = state;
    remaining_nx = remaining;
    adr_nx       = adr;
    aid_nx       = aid;
    tid_nx       = tid;
    tag_nx       = tag;
    err_nx       = err;
    wr_done_nx   = 1'b0;
    rd_done_nx   = 1'b0;
    done_err_nx  = 1'b0;
    done_id_nx   = '0;
    case (state)
      ST_IDLE: begin
        if (grant_w) begin
          adr_nx       = bus.axi_awaddr_i & ~LOW_MASK;
          remaining_nx = {1'b0, bus.axi_awlen_i} + 9'd1;
          aid_nx       = bus.axi_awid_i;
          tid_nx       = tag;
          tag_nx       = tag + MEM_ID_WIDTH'(1);
          err_nx       = (bus.axi_awburst_i != BURST_INCR);
          state_nx     = ST_WRITE;
        end else if (grant_r) begin
          adr_nx       = bus.axi_araddr_i & ~LOW_MASK;
          remaining_nx = {1'b0, bus.axi_arlen_i} + 9'd1;
          aid_nx       = bus.axi_arid_i;
          tid_nx       = tag;
          tag_nx       = tag + MEM_ID_WIDTH'(1);
          err_nx       = (bus.axi_arburst_i != BURST_INCR);
          state_nx     = ST_READ;
        end
      end
      default: begin
        if (ack) begin
          remaining_nx = remaining - chunk;
          adr_nx       = adr + (ADDRS'(chunk) << ASH);
          err_nx       = err | ack_err;
          if (last) begin
            state_nx    = ST_IDLE;
            done_err_nx = err | ack_err;
            done_id_nx  = aid;
            wr_done_nx  = wr_act;
            rd_done_nx  = rd_act;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      remaining <= '0;
      adr       <= '0;
      aid       <= '0;
      tid       <= '0;
      tag       <= '0;
      err       <= 1'b0;
      wr_done   <= 1'b0;
      rd_done   <= 1'b0;
      done_err  <= 1'b0;
      done_id   <= '0;
    end else begin
      state     <= state_nx;
      remaining <= remaining_nx;
      adr       <= adr_nx;
      aid       <= aid_nx;
      tid       <= tid_nx;
      tag       <= tag_nx;
      err       <= err_nx;
      wr_done   <= wr_done_nx;
      rd_done   <= rd_done_nx;
      done_err  <= done_err_nx;
      done_id   <= done_id_nx;
    end
  end

  assign bus.axi_awready_o = idle & grant_w;
  assign bus.axi_arready_o = idle & grant_r;

  // command fields are forced to zero whenever their request is low
  assign bus.mem_wrreq_o = wr_act;
  assign bus.mem_wrlst_o = wr_act & last;
  assign bus.mem_wrlen_o = wr_act ? LENW'(chunk - 9'd1) : '0;
  assign bus.mem_wrtid_o = wr_act ? tid : '0;
  assign bus.mem_wradr_o = wr_act ? adr : '0;

  assign bus.mem_rdreq_o = rd_act;
  assign bus.mem_rdlst_o = rd_act & last;
  assign bus.mem_rdlen_o = rd_act ? LENW'(chunk - 9'd1) : '0;
  assign bus.mem_rdtid_o = rd_act ? tid : '0;
  assign bus.mem_rdadr_o = rd_act ? adr : '0;

  assign bus.wr_done_o     = wr_done;
  assign bus.wr_done_id_o  = wr_done ? done_id : '0;
  assign bus.wr_done_err_o = wr_done & done_err;
  assign bus.rd_done_o     = rd_done;
  assign bus.rd_done_id_o  = rd_done ? done_id : '0;
  assign bus.rd_done_err_o = rd_done & done_err;

endmodule
